// File: rtl/rsa_pkg.sv
// Shared types and phase-length helpers for the systolic-array job sequencer.
// Contents:
//   state_t        - sequencer phase encoding
//   len_x/len_y    - operand stream lengths (X*N, N*Y)
//   len_comp       - skew fill plus array drain (N+X+Y-2)
//   len_out        - result words to drain (X*Y)
package rsa_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCompute,
        StWaitOut,
        StDrain,
        StDone
    } state_t;

    function automatic int unsigned len_x(int unsigned x, int unsigned n);
        return x * n;
    endfunction

    function automatic int unsigned len_y(int unsigned n, int unsigned y);
        return n * y;
    endfunction

    function automatic int unsigned len_comp(int unsigned x, int unsigned n, int unsigned y);
        return n + x + y - 2;
    endfunction

    function automatic int unsigned len_out(int unsigned x, int unsigned y);
        return x * y;
    endfunction

endpackage

// File: rtl/rsa_phase_cnt.sv
// Loadable down-counter with terminal-count flag and an up-counting address.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - cancel: stop and zero everything (wins over load)
//   load      - start a phase of load_val+1 cycles, address restarts at 0
//   load_val  - phase length minus one
//   inc       - allow the address to advance this cycle
//   run       - registered: phase in progress
//   tc        - last cycle of the running phase
//   addr      - registered address, 0 outside a phase
module rsa_phase_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    output logic             run,
    output logic             tc,
    output logic [CNT_W-1:0] addr
);

    logic [CNT_W-1:0] cnt_q;
    logic             run_q;
    logic [CNT_W-1:0] addr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            addr_q <= '0;
        end else if (clr) begin
            run_q  <= 1'b0;
            cnt_q  <= '0;
            addr_q <= '0;
        end else if (load) begin
            run_q  <= 1'b1;
            cnt_q  <= load_val;
            addr_q <= '0;
        end else if (run_q) begin
            if (cnt_q == '0) begin
                // Phase complete: park the address at 0 so the bus is quiet.
                run_q  <= 1'b0;
                addr_q <= '0;
            end else begin
                cnt_q <= cnt_q - 1'b1;
                if (inc) begin
                    addr_q <= addr_q + 1'b1;
                end
            end
        end
    end

    assign run  = run_q;
    assign addr = addr_q;
    assign tc   = run_q && (cnt_q == '0);

endmodule

// File: rtl/rsa_job_seq.sv
// Job sequencer for one X x Y systolic-array matmul with inner dimension N.
// Phases: LOAD (X and Y operand streams in parallel), COMPUTE, WAIT_OUT, DRAIN, DONE.
// Ports:
//   clk, sys_rst       - clock, asynchronous active-high reset
//   start              - job request, sampled only in idle
//   abort              - cancel, honoured in every busy phase except DONE
//   out_rdy            - result sink can take X*Y words back-to-back
//   busy/done/aborted  - job status (done, aborted are one-cycle pulses)
//   Xin_val/Yin_val    - operand stream strobes
//   out_val            - result drain strobe
//   x_rd_addr/y_rd_addr/o_rd_idx - buffer addresses, 0 when not streaming
// All outputs are registered.
module rsa_job_seq import rsa_pkg::*; #(
    parameter int unsigned X     = 3,
    parameter int unsigned N     = 4,
    parameter int unsigned Y     = 3,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic             abort,
    input  logic             out_rdy,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             Xin_val,
    output logic             Yin_val,
    output logic             out_val,
    output logic [CNT_W-1:0] x_rd_addr,
    output logic [CNT_W-1:0] y_rd_addr,
    output logic [CNT_W-1:0] o_rd_idx
);

    localparam logic [CNT_W-1:0] XLd    = CNT_W'(len_x(X, N) - 1);
    localparam logic [CNT_W-1:0] YLd    = CNT_W'(len_y(N, Y) - 1);
    localparam logic [CNT_W-1:0] CompLd = CNT_W'(len_comp(X, N, Y) - 1);
    localparam logic [CNT_W-1:0] OutLd  = CNT_W'(len_out(X, Y) - 1);

    state_t           state_q, state_d;
    logic             stream_load, p_load, clr, aborted_d;
    logic [CNT_W-1:0] p_load_val;
    logic             x_tc, y_tc, p_tc, p_run_unused;
    logic             x_run, y_run;

    rsa_phase_cnt #(.CNT_W(CNT_W)) u_x_cnt (
        .clk      (clk),
        .rst      (sys_rst),
        .clr      (clr),
        .load     (stream_load),
        .load_val (XLd),
        .inc      (1'b1),
        .run      (x_run),
        .tc       (x_tc),
        .addr     (x_rd_addr)
    );

    rsa_phase_cnt #(.CNT_W(CNT_W)) u_y_cnt (
        .clk      (clk),
        .rst      (sys_rst),
        .clr      (clr),
        .load     (stream_load),
        .load_val (YLd),
        .inc      (1'b1),
        .run      (y_run),
        .tc       (y_tc),
        .addr     (y_rd_addr)
    );

    // Shared by COMPUTE and DRAIN; the address only advances while draining.
    rsa_phase_cnt #(.CNT_W(CNT_W)) u_p_cnt (
        .clk      (clk),
        .rst      (sys_rst),
        .clr      (clr),
        .load     (p_load),
        .load_val (p_load_val),
        .inc      (state_q == StDrain),
        .run      (p_run_unused),
        .tc       (p_tc),
        .addr     (o_rd_idx)
    );

    assign Xin_val = x_run;
    assign Yin_val = y_run;

    always_comb begin
        state_d     = state_q;
        stream_load = 1'b0;
        p_load      = 1'b0;
        p_load_val  = '0;
        clr         = 1'b0;
        aborted_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    stream_load = 1'b1;
                end
            end
            StLoad: begin
                // LOAD ends when the longer of the two streams has finished.
                if ((!x_run || x_tc) && (!y_run || y_tc)) begin
                    state_d    = StCompute;
                    p_load     = 1'b1;
                    p_load_val = CompLd;
                end
            end
            StCompute: begin
                if (p_tc) begin
                    if (out_rdy) begin
                        state_d    = StDrain;
                        p_load     = 1'b1;
                        p_load_val = OutLd;
                    end else begin
                        state_d = StWaitOut;
                    end
                end
            end
            StWaitOut: begin
                if (out_rdy) begin
                    state_d    = StDrain;
                    p_load     = 1'b1;
                    p_load_val = OutLd;
                end
            end
            StDrain: begin
                if (p_tc) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q inside {StLoad, StCompute, StWaitOut, StDrain})) begin
            state_d     = StIdle;
            stream_load = 1'b0;
            p_load      = 1'b0;
            clr         = 1'b1;
            aborted_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
            out_val <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != StIdle);
            done    <= (state_d == StDone);
            aborted <= aborted_d;
            out_val <= (state_d == StDrain);
        end
    end

endmodule

// File: tb/tb_rsa_job_seq.sv
module tb_rsa_job_seq;

    localparam int unsigned X0 = 3, N0 = 4, Y0 = 3;
    localparam int unsigned X1 = 2, N1 = 3, Y1 = 4;

    // Phase lengths straight from the arithmetic rules, per DUT instance.
    localparam int LX[2] = '{X0 * N0, X1 * N1};
    localparam int LY[2] = '{N0 * Y0, N1 * Y1};
    localparam int LC[2] = '{N0 + X0 + Y0 - 2, N1 + X1 + Y1 - 2};
    localparam int LO[2] = '{X0 * Y0, X1 * Y1};

    logic clk = 1'b0;
    logic sys_rst, start, abort, out_rdy;

    logic       busy0, done0, ab0, xv0, yv0, ov0;
    logic [7:0] xa0, ya0, oi0;
    logic       busy1, done1, ab1, xv1, yv1, ov1;
    logic [7:0] xa1, ya1, oi1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt[2];

    // Reference model: job active flag, cycle index within job (1 = first LOAD
    // cycle), first drain cycle index (0 = not yet known), aborted pulse.
    int m_job[2];
    int m_t[2];
    int m_ds[2];
    bit m_abt[2];

    always #5 clk = ~clk;

    rsa_job_seq #(.X(X0), .N(N0), .Y(Y0), .CNT_W(8)) u_dut0 (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .abort     (abort),
        .out_rdy   (out_rdy),
        .busy      (busy0),
        .done      (done0),
        .aborted   (ab0),
        .Xin_val   (xv0),
        .Yin_val   (yv0),
        .out_val   (ov0),
        .x_rd_addr (xa0),
        .y_rd_addr (ya0),
        .o_rd_idx  (oi0)
    );

    rsa_job_seq #(.X(X1), .N(N1), .Y(Y1), .CNT_W(8)) u_dut1 (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .start     (start),
        .abort     (abort),
        .out_rdy   (out_rdy),
        .busy      (busy1),
        .done      (done1),
        .aborted   (ab1),
        .Xin_val   (xv1),
        .Yin_val   (yv1),
        .out_val   (ov1),
        .x_rd_addr (xa1),
        .y_rd_addr (ya1),
        .o_rd_idx  (oi1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Expected {busy, done, aborted, Xin_val, Yin_val, out_val, x_addr, y_addr, o_idx}.
    function automatic logic [29:0] model_exp(int i);
        logic       b, d, xv, yv, ov;
        logic [7:0] xa, ya, oi;
        int         t;
        b = 0; d = 0; xv = 0; yv = 0; ov = 0; xa = 0; ya = 0; oi = 0;
        t = m_t[i];
        if (m_job[i] != 0) begin
            b  = 1;
            xv = (t <= LX[i]);
            yv = (t <= LY[i]);
            if (xv) xa = 8'(t - 1);
            if (yv) ya = 8'(t - 1);
            if (m_ds[i] != 0) begin
                ov = (t >= m_ds[i]) && (t < m_ds[i] + LO[i]);
                if (ov) oi = 8'(t - m_ds[i]);
                d = (t == m_ds[i] + LO[i]);
            end
        end
        return {b, d, m_abt[i], xv, yv, ov, xa, ya, oi};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_job[i] = 0; m_t[i] = 0; m_ds[i] = 0; m_abt[i] = 0;
        end
    endtask

    task automatic model_step(input int i);
        m_abt[i] = 0;
        if (sys_rst) begin
            m_job[i] = 0;
        end else if (m_job[i] == 0) begin
            if (start) begin
                m_job[i] = 1; m_t[i] = 1; m_ds[i] = 0;
            end
        end else if (m_ds[i] != 0 && m_t[i] == m_ds[i] + LO[i]) begin
            m_job[i] = 0;
        end else if (abort) begin
            m_job[i] = 0;
            m_abt[i] = 1;
        end else begin
            // Drain may begin once the compute window has fully elapsed.
            if (m_ds[i] == 0 && m_t[i] >= max2(LX[i], LY[i]) + LC[i] && out_rdy)
                m_ds[i] = m_t[i] + 1;
            m_t[i]++;
        end
    endtask

    task automatic compare();
        check($sformatf("cyc%0d_u0", cyc),
              32'({busy0, done0, ab0, xv0, yv0, ov0, xa0, ya0, oi0}), 32'(model_exp(0)));
        check($sformatf("cyc%0d_u1", cyc),
              32'({busy1, done1, ab1, xv1, yv1, ov1, xa1, ya1, oi1}), 32'(model_exp(1)));
        if (done0) done_cnt[0]++;
        if (done1) done_cnt[1]++;
    endtask

    task automatic cycle(input logic s, input logic a, input logic r);
        start = s; abort = a; out_rdy = r;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        cyc++;
        compare();
    endtask

    initial begin
        int guard;
        sys_rst = 1'b1; start = 1'b0; abort = 1'b0; out_rdy = 1'b0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        model_reset();
        repeat (2) cycle(1'b0, 1'b0, 1'b0);
        sys_rst = 1'b0;
        repeat (2) cycle(1'b0, 1'b1, 1'b0);

        // Plain job, sink always ready.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (40) cycle(1'b0, 1'b0, 1'b1);

        // Sink not ready until well after COMPUTE finishes.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (max2(LX[0], LY[0]) + LC[0] + 5) cycle(1'b0, 1'b0, 1'b0);
        repeat (25) cycle(1'b0, 1'b0, 1'b1);

        // Abort on the fifth LOAD cycle, then a full job.
        cycle(1'b1, 1'b0, 1'b1);
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        check("abort_pulse_u0", 32'(ab0), 32'd1);
        check("abort_busy_u0", 32'(busy0), 32'd0);
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        repeat (40) cycle(1'b0, 1'b0, 1'b1);

        // start held high: two back-to-back jobs.
        done_cnt[0] = 0; done_cnt[1] = 0;
        repeat (32) cycle(1'b1, 1'b0, 1'b1);
        repeat (40) cycle(1'b0, 1'b0, 1'b1);
        check("b2b_done_u0", 32'(done_cnt[0]), 32'd2);
        check("b2b_done_u1", 32'(done_cnt[1]), 32'd2);

        // Asynchronous reset in the middle of DRAIN.
        cycle(1'b1, 1'b0, 1'b1);
        guard = 0;
        while (model_exp(0)[24] == 1'b0 && guard < 60) begin
            cycle(1'b0, 1'b0, 1'b1);
            guard++;
        end
        check("drain_reached", 32'(guard < 60), 32'd1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        #2;
        sys_rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_u0", 32'({busy0, done0, ab0, xv0, yv0, ov0, xa0, ya0, oi0}), 32'd0);
        check("async_rst_u1", 32'({busy1, done1, ab1, xv1, yv1, ov1, xa1, ya1, oi1}), 32'd0);
        cycle(1'b0, 1'b0, 1'b1);
        sys_rst = 1'b0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        repeat (10) cycle(1'b0, 1'b0, 1'b1);
        check("rst_no_done_u0", 32'(done_cnt[0]), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0),
                  logic'($urandom_range(0, 1)));
        end
        repeat (60) cycle(1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_job_seq.md
Name: rsa_job_seq

Overview:
- Job sequencer for one X×Y systolic array matmul with inner dimension N.
- Accepts a start/done job handshake from the EKF top-level control.
- Drives the array-port valid strobes Xin_val, Yin_val and out_val, plus the operand/result buffer addresses.
- Enforces the phase ordering: LOAD, COMPUTE, WAIT_OUT, DRAIN, DONE.

Parameters:
- X, 3, array rows (west inputs)
- N, 4, inner dimension (operand length per row/column)
- Y, 3, array columns (north inputs)
- CNT_W, 8, phase-counter and address width; must satisfy 2^CNT_W > max(X*N, N*Y, X*Y, N+X+Y-2)

Ports:
- clk  in  1  system clock
- sys_rst  in  1  asynchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- abort  in  1  synchronous job cancel; sampled in any busy state
- out_rdy  in  1  downstream result sink can accept X*Y words back-to-back
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, job completed
- aborted  out  1  one-cycle pulse, job cancelled
- Xin_val  out  1  west operand stream valid
- Yin_val  out  1  north operand stream valid
- out_val  out  1  result drain valid
- x_rd_addr  out  CNT_W  X-operand buffer read address, 0..X*N-1
- y_rd_addr  out  CNT_W  Y-operand buffer read address, 0..N*Y-1
- o_rd_idx  out  CNT_W  result index, 0..X*Y-1

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- On sys_rst: state IDLE; every output 0; all counters 0. The same applies if reset is asserted mid-job; no done or aborted pulse is issued.
- All outputs are registered. The value written at edge k is visible during cycle k+1.
- IDLE: start=1 at an edge moves to LOAD. Xin_val and Yin_val both become 1 in the following cycle. start is ignored in all other states.
- LOAD: X and Y stream concurrently.
  - Xin_val stays high exactly X*N cycles; x_rd_addr increments 0..X*N-1, one per cycle Xin_val is high.
  - Yin_val stays high exactly N*Y cycles; y_rd_addr increments 0..N*Y-1 likewise.
  - Each strobe drops independently when its count completes.
  - LOAD ends after max(X*N, N*Y) cycles.
- COMPUTE: all valids low for exactly N+X+Y-2 cycles (skew fill plus drain of the array).
  - At the last COMPUTE cycle: out_rdy=1 goes to DRAIN, else WAIT_OUT.
- WAIT_OUT: hold with all valids low until out_rdy=1, then DRAIN.
- DRAIN: out_val high exactly X*Y contiguous cycles; o_rd_idx increments 0..X*Y-1.
  - DRAIN is not interruptible by out_rdy. The sink must honour the out_rdy contract, because the array port restarts its count on any out_val gap.
- DONE: exactly 1 cycle; done=1, busy=1, all valids 0. Then IDLE.
- Strobe gaps: this guarantees every valid strobe is low for at least 1 cycle between jobs, as the port's rising-edge detect requires.
- Back-to-back jobs: start held high continuously produces a new LOAD one cycle after IDLE is re-entered, i.e. 2 cycles after done.
- abort=1 in any busy state except DONE: next edge goes to IDLE; all valids and addresses clear to 0; aborted=1 for 1 cycle; no done pulse.
  - abort during DONE is ignored; done still pulses.
  - abort in IDLE is ignored.
- Simultaneous start and abort in IDLE: start wins (abort ignored in IDLE).
- Counters: modulo-free. Each phase counter is loaded with its phase length minus 1 on entry and decrements to 0. Address counters reset to 0 on phase entry and never wrap within a phase.

Decomposition:
- Package rsa_pkg holds:
  - the state enum (IDLE, LOAD, COMPUTE, WAIT_OUT, DRAIN, DONE);
  - localparam functions for phase lengths: LEN_X=X*N, LEN_Y=N*Y, LEN_COMP=N+X+Y-2, LEN_OUT=X*Y.
- One sub-module: rsa_phase_cnt.
  - Function: loadable CNT_W down-counter with a terminal-count flag and an up-counting address output.
  - Instances: three, covering the X stream, the Y stream, and COMPUTE/DRAIN.

Test Plan:
- Defaults (X=3, N=4, Y=3), start pulse, out_rdy=1:
  - Xin_val and Yin_val each high 12 cycles starting the cycle after the start edge;
  - 8 idle cycles, then out_val high 9 cycles;
  - done pulse 1 cycle after the last out_val;
  - x_rd_addr 0..11 and o_rd_idx 0..8 checked.
- X=2, N=3, Y=4:
  - Xin_val drops after 6 cycles while Yin_val continues to 12;
  - COMPUTE begins only after cycle 12 and lasts 7 cycles.
- out_rdy=0 through COMPUTE, raised 5 cycles later: busy stays 1, all valids 0 until then; DRAIN starts the cycle after out_rdy rises.
- abort at LOAD cycle 5: next cycle all valids 0, aborted=1 for 1 cycle, busy=0, no done; a new start then runs a full normal job.
- start held high: two jobs back-to-back; Xin_val low for at least 1 cycle between them; exactly two done pulses.
- sys_rst asserted mid-DRAIN (asynchronously, between edges): outputs 0 immediately; after release, IDLE with no done pulse.
